// File: rtl/card_pkg.sv
// Shared constants, types and the atlas base-address helper for the card sprite loader.
package card_pkg;

    localparam int CARD_WIDTH   = 55;
    localparam int CARD_HEIGHT  = 79;
    localparam int CARD_WORDS   = CARD_WIDTH * CARD_HEIGHT;
    localparam int NUM_CARDS    = 53;
    localparam int CARD_BACK_ID = 52;
    localparam int ATLAS_AW     = 18;

    typedef logic [5:0]          card_id_t;
    typedef logic [12:0]         sprite_addr_t;
    typedef logic [ATLAS_AW-1:0] atlas_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COPY,
        ST_SWAP_WAIT
    } load_state_t;

    localparam sprite_addr_t LAST_WORD = sprite_addr_t'(CARD_WORDS - 1);

    // Out-of-range ids fall back to the card back, the last atlas entry.
    function automatic atlas_addr_t card_base(card_id_t id);
        card_id_t c;
        c = (int'(id) >= NUM_CARDS) ? card_id_t'(CARD_BACK_ID) : id;
        return atlas_addr_t'(c) * atlas_addr_t'(CARD_WORDS);
    endfunction

endpackage

// File: rtl/sprite_dpram.sv
// Two card-sized sprite buffers: one write port and one registered read port, each with a buffer select.
module sprite_dpram
    import card_pkg::*;
(
    input  logic        clk,
    input  logic        we_i,
    input  logic        wr_sel_i,
    input  logic [12:0] wr_addr_i,
    input  logic [11:0] wr_data_i,
    input  logic        rd_sel_i,
    input  logic [12:0] rd_addr_i,
    output logic [11:0] rd_data_o
);

    logic [11:0] mem0 [CARD_WORDS];
    logic [11:0] mem1 [CARD_WORDS];
    logic [11:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we_i && !wr_sel_i)
            mem0[wr_addr_i] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (we_i && wr_sel_i)
            mem1[wr_addr_i] <= wr_data_i;
    end

    // Out-of-range reads keep the old word; the caller masks them to zero.
    always_ff @(posedge clk) begin
        if (rd_addr_i < 13'(CARD_WORDS))
            rd_data_q <= rd_sel_i ? mem1[rd_addr_i] : mem0[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/card_sprite_loader.sv
// Copies one card face from the atlas ROM into the hidden sprite buffer and swaps
// buffers on the next vblank rising edge, so the drawer never sees a torn card.
module card_sprite_loader
    import card_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        load_valid,
    input  logic [5:0]  load_card_id,
    output logic        load_ready,
    output logic [17:0] atlas_addr,
    input  logic [11:0] atlas_data,
    input  logic [12:0] pixel_addr,
    output logic [11:0] rgb_pixel,
    output logic        busy,
    output logic        loaded
);

    load_state_t      state_q;
    logic             front_q;
    logic             vblnk_q;
    logic             issuing_q;
    logic [17:0]      base_q;
    logic [17:0]      base_d;
    logic [17:0]      atlas_addr_q;
    logic [12:0]      rd_cnt_q;
    logic [12:0]      wr_cnt_q;
    logic [ROM_LAT:0] vld_pipe_q;
    logic             busy_q;
    logic             load_ready_q;
    logic             loaded_q;
    logic             in_range_q;
    logic             issue;
    logic             wr_en;
    logic             vblnk_rise;
    logic [11:0]      ram_rdata;

    assign base_d     = card_base(load_card_id);
    assign issue      = (state_q == ST_COPY) && issuing_q;
    assign wr_en      = (state_q == ST_COPY) && vld_pipe_q[ROM_LAT];
    assign vblnk_rise = vblnk && !vblnk_q;

    // vld_pipe_q[0] rises with atlas_addr; bit ROM_LAT marks the cycle its data is on atlas_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            front_q      <= 1'b0;
            vblnk_q      <= 1'b0;
            issuing_q    <= 1'b0;
            base_q       <= '0;
            atlas_addr_q <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            vld_pipe_q   <= '0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            vblnk_q    <= vblnk;
            loaded_q   <= 1'b0;
            vld_pipe_q <= {vld_pipe_q[ROM_LAT-1:0], issue};
            case (state_q)
                ST_IDLE: begin
                    busy_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                    if (load_valid && load_ready_q) begin
                        base_q       <= base_d;
                        rd_cnt_q     <= '0;
                        wr_cnt_q     <= '0;
                        issuing_q    <= 1'b1;
                        busy_q       <= 1'b1;
                        load_ready_q <= 1'b0;
                        state_q      <= ST_COPY;
                    end
                end
                ST_COPY: begin
                    if (issuing_q) begin
                        atlas_addr_q <= base_q + 18'(rd_cnt_q);
                        if (rd_cnt_q == LAST_WORD)
                            issuing_q <= 1'b0;
                        else
                            rd_cnt_q <= rd_cnt_q + 13'd1;
                    end
                    if (wr_en) begin
                        wr_cnt_q <= wr_cnt_q + 13'd1;
                        if (wr_cnt_q == LAST_WORD)
                            state_q <= ST_SWAP_WAIT;
                    end
                end
                ST_SWAP_WAIT: begin
                    if (vblnk_rise) begin
                        front_q      <= ~front_q;
                        loaded_q     <= 1'b1;
                        busy_q       <= 1'b0;
                        load_ready_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            in_range_q <= 1'b0;
        else
            in_range_q <= pixel_addr < 13'(CARD_WORDS);
    end

    sprite_dpram u_ram (
        .clk       (clk),
        .we_i      (wr_en),
        .wr_sel_i  (~front_q),
        .wr_addr_i (wr_cnt_q),
        .wr_data_i (atlas_data),
        .rd_sel_i  (front_q),
        .rd_addr_i (pixel_addr),
        .rd_data_o (ram_rdata)
    );

    assign rgb_pixel  = in_range_q ? ram_rdata : 12'h000;
    assign atlas_addr = atlas_addr_q;
    assign busy       = busy_q;
    assign load_ready = load_ready_q;
    assign loaded     = loaded_q;

endmodule

// File: tb/tb_card_sprite_loader.sv
// Scoreboard bench: ROM_LAT=1 and ROM_LAT=3 loaders share stimulus and must both match a card-level model.
module tb_card_sprite_loader;
    import card_pkg::*;

    logic        clk = 1'b0;
    logic        rst, vblnk, load_valid;
    logic [5:0]  load_card_id;
    logic [12:0] pixel_addr;
    logic        lr1, lr3, busy1, busy3, ld1, ld3;
    logic [17:0] aa1, aa3;
    logic [11:0] ad1, ad3, rgb1, rgb3, r3a, r3b;

    int   n_cmp = 0, n_err = 0;
    int   cyc = 0;
    logic rd_v = 1'b0, rd_v_d = 1'b0;
    bit   rd_en = 1'b1;
    int   force_addr = -1;
    int   front_card = -1;
    int   pend = -1;
    int   acc_cyc = 0;
    logic [11:0] exp_rgb_q[$];
    int          exp_ld_q[$];

    always #5 clk = ~clk;

    card_sprite_loader #(.ROM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .vblnk(vblnk), .load_valid(load_valid), .load_card_id(load_card_id),
        .load_ready(lr1), .atlas_addr(aa1), .atlas_data(ad1), .pixel_addr(pixel_addr),
        .rgb_pixel(rgb1), .busy(busy1), .loaded(ld1));

    card_sprite_loader #(.ROM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .vblnk(vblnk), .load_valid(load_valid), .load_card_id(load_card_id),
        .load_ready(lr3), .atlas_addr(aa3), .atlas_data(ad3), .pixel_addr(pixel_addr),
        .rgb_pixel(rgb3), .busy(busy3), .loaded(ld3));

    // Atlas ROM model: each word holds the low 12 bits of its own address.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_v_d <= rd_v;
        ad1    <= aa1[11:0];
        r3a    <= aa3[11:0];
        r3b    <= r3a;
        ad3    <= r3b;
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [11:0] pix_model(int card, int a);
        if (a >= CARD_WORDS) return 12'h000;
        return 12'((card * CARD_WORDS + a) % 4096);
    endfunction

    // Monitor: pops an expectation whenever a read result or a loaded pulse is presented.
    always @(negedge clk) begin
        logic [11:0] e;
        int c;
        if (rd_v_d) begin
            if (exp_rgb_q.size() == 0) chk("rgb_underflow", 1, 0);
            else begin
                e = exp_rgb_q.pop_front();
                chk("rgb_lat1", 32'(rgb1), 32'(e));
                chk("rgb_lat3", 32'(rgb3), 32'(e));
            end
        end
        if (ld1 === 1'b1 || ld3 === 1'b1) begin
            if (exp_ld_q.size() == 0) chk("loaded_unexpected", 32'({ld1, ld3}), 0);
            else begin
                c = exp_ld_q.pop_front();
                chk("loaded_cycle", cyc, c);
                chk("loaded_both", 32'({ld1, ld3}), 3);
            end
        end
    end

    task automatic step();
        int a;
        rd_v = 1'b0;
        if (!rst && rd_en) begin
            if (force_addr >= 0) a = force_addr;
            else case ($urandom_range(0, 9))
                0: a = 0;
                1: a = CARD_WORDS - 1;
                2: a = CARD_WORDS;
                3: a = $urandom_range(CARD_WORDS, 8191);
                default: a = $urandom_range(0, CARD_WORDS - 1);
            endcase
            if (a >= CARD_WORDS || front_card >= 0) begin
                pixel_addr = 13'(a);
                rd_v = 1'b1;
                exp_rgb_q.push_back(pix_model(front_card, a));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd_at(int a);
        force_addr = a;
        step();
        force_addr = -1;
    endtask

    task automatic vblank_rise();
        bit sw;
        sw = (pend >= 0) && (cyc - acc_cyc > CARD_WORDS + 20);
        if (sw) chk("busy_before_swap", 32'({busy1, busy3}), 3);
        vblnk = 1'b1;
        if (sw) exp_ld_q.push_back(cyc + 1);
        step();
        if (sw) begin
            front_card = pend;
            pend = -1;
            chk("busy_after_swap", 32'({busy1, busy3}), 0);
            chk("ready_after_swap", 32'({lr1, lr3}), 3);
        end
        repeat (3) step();
        vblnk = 1'b0;
        step();
    endtask

    task automatic do_load(int id, int abort_at, int vbl_at);
        int base, n;
        n = 0;
        while (!(lr1 === 1'b1 && lr3 === 1'b1) && n < 20) begin step(); n++; end
        chk("ready_wait", 32'({lr1, lr3}), 3);
        load_valid = 1'b1;
        load_card_id = 6'(id);
        step();
        load_valid = 1'b0;
        pend = (id >= NUM_CARDS) ? NUM_CARDS - 1 : id;
        acc_cyc = cyc;
        base = pend * CARD_WORDS;
        n = 0;
        while (!(aa1 == 18'(base + 1) && aa3 == 18'(base + 1)) && n < 8) begin step(); n++; end
        chk("addr_start_lat1", 32'(aa1), base + 1);
        chk("addr_start_lat3", 32'(aa3), base + 1);
        for (int i = 2; i < CARD_WORDS; i++) begin
            if (i == abort_at) begin
                // the read in flight sees the reset edge and must come back zero
                if (rd_v) begin void'(exp_rgb_q.pop_back()); exp_rgb_q.push_back(12'h000); end
                rst = 1'b1;
                step();
                chk("abort_busy", 32'({busy1, busy3}), 0);
                chk("abort_ready", 32'({lr1, lr3}), 0);
                chk("abort_loaded", 32'({ld1, ld3}), 0);
                chk("abort_rgb", 32'({rgb1, rgb3}), 0);
                rst = 1'b0;
                front_card = -1;
                pend = -1;
                step();
                chk("abort_ready_after", 32'({lr1, lr3}), 3);
                return;
            end
            if (i == vbl_at) vblnk = 1'b1;
            if (i == 1000) begin
                load_valid = 1'b1;
                load_card_id = 6'($urandom_range(0, 63));
                chk("ready_in_copy", 32'({lr1, lr3}), 0);
            end
            if (i == 1001) load_valid = 1'b0;
            step();
            chk("addr_seq_lat1", 32'(aa1), base + i);
            chk("addr_seq_lat3", 32'(aa3), base + i);
        end
        repeat (30) step();
        chk("busy_swap_wait", 32'({busy1, busy3}), 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; vblnk = 1'b0; load_valid = 1'b0; load_card_id = '0; pixel_addr = '0;
        repeat (3) begin
            step();
            chk("rst_rgb", 32'({rgb1, rgb3}), 0);
            chk("rst_busy", 32'({busy1, busy3}), 0);
            chk("rst_loaded", 32'({ld1, ld3}), 0);
            chk("rst_ready", 32'({lr1, lr3}), 0);
        end
        rst = 1'b0;
        step();
        chk("ready_after_rst", 32'({lr1, lr3}), 3);

        do_load(5, -1, -1);
        vblank_rise();
        rd_at(0); rd_at(CARD_WORDS - 1); rd_at(5000); rd_at(CARD_WORDS); rd_at(8191);
        repeat (40) step();

        // new card stays hidden until the swap
        do_load($urandom_range(0, 52), -1, -1);
        rd_at(0); rd_at(CARD_WORDS - 1);
        vblank_rise();
        rd_at(0); rd_at(CARD_WORDS - 1);
        repeat (40) step();

        // clamp, with vblnk already high when the copy finishes
        do_load(60, -1, 2000);
        vblnk = 1'b0;
        step();
        vblank_rise();
        rd_at(0); rd_at(CARD_WORDS - 1);
        repeat (40) step();

        do_load($urandom_range(0, 52), 2000, -1);
        vblank_rise();
        repeat (20) step();

        do_load(0, -1, -1);
        vblank_rise();
        rd_at(0); rd_at(CARD_WORDS - 1); rd_at(5000);
        repeat (40) step();

        rd_en = 1'b0;
        repeat (4) step();
        chk("rgb_pending", exp_rgb_q.size(), 0);
        chk("loaded_pending", exp_ld_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
